// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state codes, next-PC select codes,
// the default reset vector and the branch displacement helper.
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_PEND   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_JR     = 3'd4
  } sel_e;

  // Word offset from the instruction, sign-extended and scaled to bytes.
  function automatic logic [31:0] branch_disp(input logic [15:0] off);
    return {{14{off[15]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: computes every candidate target and picks one
// by priority jr > jump > branch > pending redirect > sequential.
module next_pc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_addr,
  input  logic [31:0] pend_pc,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic        pend_valid,
  output logic [31:0] pc_plus4,
  output logic [31:0] redirect_pc,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  sel_e        sel;

  assign pc_plus4  = pc + 32'd4;
  assign branch_pc = pc_plus4 + branch_disp(branch_offset);
  assign jump_pc   = {pc_plus4[31:28], jump_target, 2'b00};
  assign redirect  = jr | jump | branch_taken;

  always_comb begin
    sel = SEL_SEQ;
    if (jr)                sel = SEL_JR;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
    else if (pend_valid)   sel = SEL_PEND;
  end

  // The target captured into the pending buffer ignores pend/sequential choices.
  always_comb begin
    redirect_pc = branch_pc;
    if (jr)        redirect_pc = jr_addr;
    else if (jump) redirect_pc = jump_pc;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_JR:     next_pc = jr_addr;
      SEL_JUMP:   next_pc = jump_pc;
      SEL_BRANCH: next_pc = branch_pc;
      SEL_PEND:   next_pc = pend_pc;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: boot/run/halt/fault FSM, stall-time
// pending-redirect buffer and a saturating issued-instruction counter.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_target,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  input  logic             halt_req,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] issue_count
);

  logic [1:0]  state;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] next_pc;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        jr_misaligned;

  next_pc_calc u_next_pc_calc (
    .pc            (pc),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_addr       (jr_addr),
    .pend_pc       (pend_pc),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .jr            (jr),
    .pend_valid    (pend_valid),
    .pc_plus4      (pc_plus4),
    .redirect_pc   (redirect_pc),
    .next_pc       (next_pc),
    .redirect      (redirect)
  );

  assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

  // During a stall only the pending buffer moves; halt and fault are judged on live cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      pc          <= RESET_VEC;
      pend_valid  <= 1'b0;
      pend_pc     <= RESET_VEC;
      issue_count <= '0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (stall) begin
            if (redirect) begin
              pend_pc    <= redirect_pc;
              pend_valid <= 1'b1;
            end
          end else begin
            if (issue_count != {CNT_W{1'b1}})
              issue_count <= issue_count + CNT_W'(1);
            pend_valid <= 1'b0;
            if (halt_req)           state <= ST_HALTED;
            else if (jr_misaligned) state <= ST_FAULT;
            else                    pc    <= next_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign fetch_valid = (state == ST_RUN);
  assign halted      = (state == ST_HALTED);
  assign misalign    = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a behavioural model predicts each cycle's
// outputs when stimulus is driven; predictions are popped and compared after the edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        halt_req = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] issue_count;

  pc_fetch_unit #(.RESET_VEC(32'h0000_0000), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_addr       (jr_addr),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .halted        (halted),
    .misalign      (misalign),
    .issue_count   (issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        hlt;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state; modes: 0 boot, 1 run, 2 halted, 3 fault
  int          m_mode = 0;
  logic [31:0] m_pc = '0;
  logic        m_pv = 1'b0;
  logic [31:0] m_pp = '0;
  logic [31:0] m_cnt = '0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] targetOf(input logic [31:0] cur, input logic b, input logic [15:0] off,
                                           input logic j, input logic [25:0] jt, input logic r,
                                           input logic [31:0] ja);
    logic [31:0] seq;
    logic [31:0] sext;
    seq  = cur + 32'd4;
    sext = {{16{off[15]}}, off};
    if (r) return ja;
    if (j) return {seq[31:28], jt, 2'b00};
    if (b) return seq + (sext << 2);
    return seq;
  endfunction

  task automatic modelStep(input logic r_i, input logic s_i, input logic b_i, input logic [15:0] off_i,
                           input logic j_i, input logic [25:0] jt_i, input logic jr_i,
                           input logic [31:0] ja_i, input logic h_i);
    if (r_i) begin
      m_mode = 0; m_pc = 32'h0; m_pv = 1'b0; m_pp = 32'h0; m_cnt = 32'h0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (s_i) begin
        if (b_i || j_i || jr_i) begin
          m_pp = targetOf(m_pc, b_i, off_i, j_i, jt_i, jr_i, ja_i);
          m_pv = 1'b1;
        end
      end else begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (h_i) m_mode = 2;
        else if (jr_i && ja_i[1:0] != 2'b00) m_mode = 3;
        else if (b_i || j_i || jr_i) m_pc = targetOf(m_pc, b_i, off_i, j_i, jt_i, jr_i, ja_i);
        else if (m_pv) m_pc = m_pp;
        else m_pc = m_pc + 32'd4;
        m_pv = 1'b0;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict the result, then compare after the edge.
  task automatic applyStimulus(input logic r_i, input logic s_i, input logic b_i, input logic [15:0] off_i,
                               input logic j_i, input logic [25:0] jt_i, input logic jr_i,
                               input logic [31:0] ja_i, input logic h_i);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r_i; stall = s_i; branch_taken = b_i; branch_offset = off_i;
    jump = j_i; jump_target = jt_i; jr = jr_i; jr_addr = ja_i; halt_req = h_i;
    modelStep(r_i, s_i, b_i, off_i, j_i, jt_i, jr_i, ja_i, h_i);
    e.pc = m_pc; e.fv = (m_mode == 1); e.hlt = (m_mode == 2); e.mis = (m_mode == 3); e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      checkOutput("pc", {32'h0, pc}, {32'h0, got.pc});
      checkOutput("pc_plus4", {32'h0, pc_plus4}, {32'h0, got.pc + 32'd4});
      checkOutput("fetch_valid", {63'h0, fetch_valid}, {63'h0, got.fv});
      checkOutput("halted", {63'h0, halted}, {63'h0, got.hlt});
      checkOutput("misalign", {63'h0, misalign}, {63'h0, got.mis});
      checkOutput("issue_count", {32'h0, issue_count}, {32'h0, got.cnt});
    end
  endtask

  task automatic freeCycle();
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
  endtask

  task automatic jrTo(input logic [31:0] a);
    applyStimulus(0, 0, 0, 16'h0, 0, 26'h0, 1, a, 0);
  endtask

  initial begin
    logic [31:0] ra;
    // Reset then free-run: pc 0,0,4,8,C
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    repeat (4) freeCycle();
    // Branch backward and forward from 0x100
    jrTo(32'h0000_0100);
    applyStimulus(0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0);
    jrTo(32'h0000_0100);
    applyStimulus(0, 0, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0);
    // Jump keeps the upper nibble; jr beats jump
    jrTo(32'h1000_0040);
    applyStimulus(0, 0, 0, 16'h0, 1, 26'h000_0010, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 26'h000_0010, 1, 32'h0000_0200, 0);
    // Two redirects under stall; the newest one is taken on release
    applyStimulus(0, 1, 0, 16'h0, 1, 26'h000_0020, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 16'h0, 1, 26'h000_0030, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    freeCycle();
    freeCycle();
    // Pending redirect overridden by a fresh redirect on the release cycle
    applyStimulus(0, 1, 1, 16'h0010, 0, 26'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 1, 26'h000_0100, 0, 32'h0, 0);
    freeCycle();
    // Wrap at the top of the address space
    jrTo(32'hFFFF_FFFC);
    freeCycle();
    // Random run traffic, jr targets kept word-aligned
    for (int i = 0; i < 30; i++) begin
      ra = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 16'($urandom()),
                    1'($urandom_range(0, 4) == 0), 26'($urandom()), 1'($urandom_range(0, 5) == 0), ra, 0);
    end
    // Misaligned jr faults and freezes pc until reset
    jrTo(32'h0000_0202);
    applyStimulus(0, 0, 1, 16'h0008, 1, 26'h0, 0, 32'h0, 0);
    jrTo(32'h0000_0300);
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    freeCycle();
    freeCycle();
    // Halt wins over a same-cycle branch; reset recovers from halt
    applyStimulus(0, 0, 1, 16'h0040, 0, 26'h0, 0, 32'h0, 1);
    freeCycle();
    applyStimulus(0, 0, 0, 16'h0, 1, 26'h000_0400, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    freeCycle();
    freeCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
